// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 decoding for the data-memory port arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Returns 1 for a legal, aligned access; the error flag is its complement.
   function automatic logic is_legal(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_B, F3_BU: ok = 1'b1;
         F3_H, F3_HU: ok = ~addr_lo[0];
         F3_W:        ok = (addr_lo == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module dmem_rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_last,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shared data-memory arbiter: grants one of two ports, runs a single-cycle
// memory access, and returns a one-cycle response pulse to the requester.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [DM_ADDRESS-1:0] req_addr   [2],
   input  logic [DATA_W-1:0]     req_wdata  [2],
   input  logic [2:0]            req_funct3 [2],
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata  [2],
   output logic [1:0]            rsp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_W-1:0]     mem_rdata
);

   state_t                state_reg;
   logic                  rr_last_reg;
   logic                  cap_port_reg;
   logic                  cap_we_reg;
   logic                  cap_err_reg;

   logic [1:0]            grant;
   logic                  arb_enable;
   logic                  handshake;
   logic                  win_port;
   logic                  win_we;
   logic                  win_legal;
   logic [DM_ADDRESS-1:0] win_addr;
   logic [DATA_W-1:0]     win_wdata;
   logic [2:0]            win_funct3;

   logic [1:0]            rsp_hit;
   logic [1:0]            rsp_err_next;
   logic [DATA_W-1:0]     rsp_rdata_next [2];

   // Holding ready low while reset is asserted keeps reset outputs quiet.
   assign arb_enable = (state_reg == IDLE) && rst_n;

   dmem_rr_arb2 u_rr (
      .req     (req_valid),
      .rr_last (rr_last_reg),
      .enable  (arb_enable),
      .grant   (grant)
   );

   assign req_ready  = grant;
   assign handshake  = |grant;
   assign win_port   = grant[1];
   assign win_we     = req_we[win_port];
   assign win_addr   = req_addr[win_port];
   assign win_wdata  = req_wdata[win_port];
   assign win_funct3 = req_funct3[win_port];
   assign win_legal  = is_legal(win_funct3, win_addr[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         rr_last_reg  <= 1'b1;
         cap_port_reg <= 1'b0;
         cap_we_reg   <= 1'b0;
         cap_err_reg  <= 1'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_funct3   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (handshake) begin
                  state_reg    <= ACCESS;
                  rr_last_reg  <= win_port;
                  cap_port_reg <= win_port;
                  cap_we_reg   <= win_we;
                  cap_err_reg  <= ~win_legal;
                  // An illegal request still occupies a slot but never strobes memory.
                  mem_read     <= win_legal & ~win_we;
                  mem_write    <= win_legal & win_we;
                  mem_addr     <= win_addr;
                  mem_wdata    <= win_wdata;
                  mem_funct3   <= win_funct3;
               end
            end
            ACCESS: begin
               state_reg  <= IDLE;
               mem_read   <= 1'b0;
               mem_write  <= 1'b0;
               mem_addr   <= '0;
               mem_wdata  <= '0;
               mem_funct3 <= '0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rsp_hit = (state_reg == ACCESS) ? {cap_port_reg, ~cap_port_reg} : 2'b00;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_next
      assign rsp_err_next[gi]   = rsp_hit[gi] ? cap_err_reg : rsp_err[gi];
      assign rsp_rdata_next[gi] = !rsp_hit[gi]               ? rsp_rdata[gi] :
                                  (cap_err_reg | cap_we_reg) ? '0 : mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 2'b00;
         rsp_err   <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            rsp_rdata[i] <= '0;
         end
      end else begin
         rsp_valid <= rsp_hit;
         rsp_err   <= rsp_err_next;
         for (int i = 0; i < 2; i++) begin
            rsp_rdata[i] <= rsp_rdata_next[i];
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [8:0]  req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [2:0]  req_funct3 [2];
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata  [2];
   logic [1:0]  rsp_err;
   logic        mem_read;
   logic        mem_write;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_funct3 (mem_funct3),
      .mem_rdata  (mem_rdata)
   );

   // Word-wide memory: unwritten words return a fixed pattern, stores commit on the falling edge.
   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   logic [31:0]  envmem [128];
   logic [127:0] written = '0;

   assign mem_rdata = written[mem_addr[8:2]] ? envmem[mem_addr[8:2]] : init_word(int'(mem_addr[8:2]));

   always @(negedge clk) begin
      if (mem_write) begin
         envmem[mem_addr[8:2]]  <= mem_wdata;
         written[mem_addr[8:2]] <= 1'b1;
      end
   end

   function automatic logic ref_legal(input logic [2:0] f3, input logic [8:0] a);
      int ai;
      ai = int'(a);
      if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) return (ai % 2) == 0;
      if (f3 == 3'd2) return (ai % 4) == 0;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [2:0] f);
      req_valid[p]  = v;
      req_we[p]     = we;
      req_addr[p]   = a;
      req_wdata[p]  = d;
      req_funct3[p] = f;
   endtask

   task automatic clear_reqs();
      set_req(0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
      set_req(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
   endtask

   task automatic do_reset();
      clear_reqs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_reqs();
      rst_n = 1'b0;
      req_valid = 2'b11;
      #3;
      tests_run++;
      if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
      tests_run++;
      if ({mem_read, mem_write} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
      tests_run++;
      if ({mem_addr, mem_wdata, mem_funct3} !== '0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_funct3); end
      tests_run++;
      if ({rsp_valid, rsp_err} !== 4'b0) begin tests_failed++; $display("FAIL reset_rsp: got valid %b err %b expected 0", rsp_valid, rsp_err); end
      tests_run++;
      if (rsp_rdata[0] !== 32'h0 || rsp_rdata[1] !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h %h expected 0", rsp_rdata[0], rsp_rdata[1]); end
      tick();
      tick();
      clear_reqs();
      rst_n = 1'b1;
      $display("[TB] reset checked");
   endtask

   task automatic test_store_load();
      tick();
      set_req(0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
      #1;
      tests_run++;
      if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL sw_ready: got %b expected 01", req_ready); end
      tick();
      clear_reqs();
      #1;
      tests_run++;
      if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 9'h010 || mem_wdata !== 32'hDEADBEEF || mem_funct3 !== 3'b010) begin
         tests_failed++;
         $display("FAIL sw_access: got rd %b wr %b addr %h data %h f3 %b expected 0 1 010 deadbeef 010", mem_read, mem_write, mem_addr, mem_wdata, mem_funct3);
      end
      tests_run++;
      if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL sw_busy_ready: got %b expected 00", req_ready); end
      tick();
      #1;
      tests_run++;
      if (mem_write !== 1'b0 || rsp_valid !== 2'b01 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
         tests_failed++;
         $display("FAIL sw_rsp: got wr %b valid %b err %b rdata %h expected 0 01 0 0", mem_write, rsp_valid, rsp_err[0], rsp_rdata[0]);
      end
      $display("[TB] port0 SW 0x010 <= deadbeef");
      tick();
      #1;
      tests_run++;
      if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL sw_rsp_pulse: got %b expected 00", rsp_valid); end
      set_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      #1;
      tests_run++;
      if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL lw_ready: got %b expected 01", req_ready); end
      tick();
      clear_reqs();
      #1;
      tests_run++;
      if ({mem_read, mem_write} !== 2'b10) begin tests_failed++; $display("FAIL lw_strobe: got %b expected 10", {mem_read, mem_write}); end
      tick();
      #1;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_rdata[0] !== 32'hDEADBEEF || rsp_err[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_rsp: got valid %b rdata %h err %b expected 01 deadbeef 0", rsp_valid, rsp_rdata[0], rsp_err[0]);
      end
      $display("[TB] port0 LW 0x010 => %h", rsp_rdata[0]);
   endtask

   task automatic test_back_to_back();
      tick();
      set_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      tick();
      clear_reqs();
      tick();
      set_req(0, 1'b1, 1'b0, 9'h014, 32'h0, 3'b010);
      #1;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_rdata[0] !== 32'hDEADBEEF || req_ready !== 2'b01) begin
         tests_failed++;
         $display("FAIL b2b_first: got valid %b rdata %h ready %b expected 01 deadbeef 01", rsp_valid, rsp_rdata[0], req_ready);
      end
      tick();
      clear_reqs();
      #1;
      tests_run++;
      if (mem_read !== 1'b1 || mem_addr !== 9'h014 || rsp_valid !== 2'b00) begin
         tests_failed++;
         $display("FAIL b2b_access: got rd %b addr %h valid %b expected 1 014 00", mem_read, mem_addr, rsp_valid);
      end
      tick();
      #1;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_rdata[0] !== init_word(5)) begin
         tests_failed++;
         $display("FAIL b2b_second: got valid %b rdata %h expected 01 %h", rsp_valid, rsp_rdata[0], init_word(5));
      end
      $display("[TB] port0 back-to-back LW 0x010, 0x014 => %h", rsp_rdata[0]);
   endtask

   task automatic test_errors();
      int          c_port [5] = '{1, 1, 1, 0, 0};
      logic        c_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [8:0]  c_addr [5] = '{9'h010, 9'h003, 9'h006, 9'h020, 9'h040};
      logic [2:0]  c_f3   [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110};
      logic        c_err  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] exp_rd;
      logic [1:0]  exp_rdy;
      for (int c = 0; c < 5; c++) begin
         tick();
         set_req(c_port[c], 1'b1, c_we[c], c_addr[c], 32'h1234_5678, c_f3[c]);
         exp_rdy = (c_port[c] == 1) ? 2'b10 : 2'b01;
         exp_rd  = c_err[c] ? 32'h0 : 32'hDEADBEEF;
         #1;
         tests_run++;
         if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL err%0d_ready: got %b expected %b", c, req_ready, exp_rdy); end
         tick();
         clear_reqs();
         #1;
         tests_run++;
         if ({mem_read, mem_write} !== {~c_err[c] & ~c_we[c], ~c_err[c] & c_we[c]}) begin
            tests_failed++;
            $display("FAIL err%0d_strobe: got rd %b wr %b expected err=%b", c, mem_read, mem_write, c_err[c]);
         end
         tick();
         #1;
         tests_run++;
         if (rsp_valid !== exp_rdy || rsp_err[c_port[c]] !== c_err[c] || rsp_rdata[c_port[c]] !== exp_rd || {mem_read, mem_write} !== 2'b00) begin
            tests_failed++;
            $display("FAIL err%0d_rsp: got valid %b err %b rdata %h expected %b %b %h", c, rsp_valid, rsp_err[c_port[c]], rsp_rdata[c_port[c]], exp_rdy, c_err[c], exp_rd);
         end
         $display("[TB] port%0d f3 %b addr %h => err %b rdata %h", c_port[c], c_f3[c], c_addr[c], rsp_err[c_port[c]], rsp_rdata[c_port[c]]);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_rdy;
      logic [1:0] exp_rsp;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         tick();
         set_req(0, k < 8, 1'b0, 9'h010, 32'h0, 3'b010);
         set_req(1, k < 8, 1'b0, 9'h014, 32'h0, 3'b010);
         exp_rdy = (k < 8 && k % 2 == 0) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_rsp = (k >= 2 && k % 2 == 0) ? ((((k - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         #1;
         tests_run++;
         if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_grant_c%0d: got %b expected %b", k, req_ready, exp_rdy); end
         tests_run++;
         if (rsp_valid !== exp_rsp) begin tests_failed++; $display("FAIL rr_rsp_c%0d: got %b expected %b", k, rsp_valid, exp_rsp); end
         $display("[TB] tie cycle %0d grant %b rsp %b", k, req_ready, rsp_valid);
      end
      clear_reqs();
   endtask

   task automatic test_reset_mid_access();
      tick();
      set_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      tick();
      clear_reqs();
      #1;
      tests_run++;
      if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre: got rd %b expected 1", mem_read); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 9'h0) begin
         tests_failed++;
         $display("FAIL rst_mid_strobe: got rd %b wr %b addr %h expected 0 0 0", mem_read, mem_write, mem_addr);
      end
      tick();
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_norsp: got %b expected 00", rsp_valid); end
      set_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      set_req(1, 1'b1, 1'b0, 9'h014, 32'h0, 3'b010);
      #1;
      tests_run++;
      if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_tie: got %b expected 01", req_ready); end
      tick();
      clear_reqs();
      #1;
      tests_run++;
      if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_norsp2: got %b expected 00", rsp_valid); end
      tick();
      tick();
      $display("[TB] reset during ACCESS, next tie granted %s", "port0");
   endtask

   // Transaction-level model: each grant occupies one memory cycle and is
   // answered one cycle later; rr_last names the most recent winner.
   task automatic test_random();
      logic [31:0] shadow [128];
      logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [2:0]  bad_f3   [3] = '{3'd3, 3'd6, 3'd7};
      logic        pend [2];
      logic        p_we [2];
      logic [8:0]  p_addr [2];
      logic [31:0] p_wd [2];
      logic [2:0]  p_f3 [2];
      logic        m_acc, m_we, m_err, m_rv, m_rerr;
      int          m_port, m_rport, rr_last, winner, r;
      logic [8:0]  m_addr;
      logic [31:0] m_wd, m_rdata;
      logic [2:0]  m_f3;
      logic [31:0] hold_rdata [2];
      logic        hold_err [2];
      logic [1:0]  exp_rdy;

      do_reset();
      for (int i = 0; i < 128; i++) shadow[i] = written[i] ? envmem[i] : init_word(i);
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; hold_rdata[p] = 32'h0; hold_err[p] = 1'b0;
      end
      m_acc = 1'b0; m_rv = 1'b0; rr_last = 1;
      m_we = 1'b0; m_err = 1'b0; m_rerr = 1'b0; m_port = 0; m_rport = 0;
      m_addr = '0; m_wd = '0; m_f3 = '0; m_rdata = '0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) != 0) begin
               pend[p] = 1'b1;
               p_we[p] = 1'($urandom_range(0, 1));
               r = int'($urandom_range(0, 9));
               p_f3[p] = (r < 8) ? legal_f3[r % 5] : bad_f3[$urandom_range(0, 2)];
               p_addr[p] = 9'($urandom_range(0, 511));
               if ($urandom_range(0, 3) != 0) begin
                  if (p_f3[p] == 3'd1 || p_f3[p] == 3'd5) p_addr[p][0] = 1'b0;
                  if (p_f3[p] == 3'd2) p_addr[p][1:0] = 2'b00;
               end
               p_wd[p] = $urandom;
            end else if (pend[p] && $urandom_range(0, 9) == 0) begin
               pend[p] = 1'b0;
            end
            set_req(p, pend[p], p_we[p], p_addr[p], p_wd[p], p_f3[p]);
         end
         #1;
         winner = -1;
         if (!m_acc) begin
            if (pend[0] && pend[1]) winner = 1 - rr_last;
            else if (pend[0])      winner = 0;
            else if (pend[1])      winner = 1;
         end
         exp_rdy = (winner < 0) ? 2'b00 : ((winner == 0) ? 2'b01 : 2'b10);
         tests_run++;
         if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
         tests_run++;
         if (mem_read !== (m_acc && !m_err && !m_we) || mem_write !== (m_acc && !m_err && m_we) ||
             mem_addr !== (m_acc ? m_addr : 9'h0) || mem_wdata !== (m_acc ? m_wd : 32'h0) ||
             mem_funct3 !== (m_acc ? m_f3 : 3'h0)) begin
            tests_failed++;
            $display("FAIL rand_mem c%0d: got rd %b wr %b addr %h data %h f3 %b expected acc %b err %b we %b addr %h data %h f3 %b",
                     cyc, mem_read, mem_write, mem_addr, mem_wdata, mem_funct3, m_acc, m_err, m_we, m_addr, m_wd, m_f3);
         end
         if (m_rv) begin
            hold_rdata[m_rport] = m_rdata;
            hold_err[m_rport]   = m_rerr;
            $display("[TB] rsp port%0d rdata %h err %b", m_rport, m_rdata, m_rerr);
         end
         for (int p = 0; p < 2; p++) begin
            tests_run++;
            if (rsp_valid[p] !== (m_rv && m_rport == p) || rsp_rdata[p] !== hold_rdata[p] || rsp_err[p] !== hold_err[p]) begin
               tests_failed++;
               $display("FAIL rand_rsp%0d c%0d: got valid %b rdata %h err %b expected %b %h %b",
                        p, cyc, rsp_valid[p], rsp_rdata[p], rsp_err[p], (m_rv && m_rport == p), hold_rdata[p], hold_err[p]);
            end
         end
         // Advance the model across the coming rising edge.
         m_rv = m_acc;
         if (m_acc) begin
            m_rport = m_port;
            m_rerr  = m_err;
            m_rdata = (m_err || m_we) ? 32'h0 : shadow[m_addr[8:2]];
            if (!m_err && m_we) shadow[m_addr[8:2]] = m_wd;
         end
         if (winner >= 0) begin
            m_port  = winner;
            m_we    = p_we[winner];
            m_addr  = p_addr[winner];
            m_wd    = p_wd[winner];
            m_f3    = p_f3[winner];
            m_err   = !ref_legal(p_f3[winner], p_addr[winner]);
            rr_last = winner;
            pend[winner] = 1'b0;
            m_acc   = 1'b1;
         end else begin
            m_acc = 1'b0;
         end
      end
      clear_reqs();
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_errors();
      test_fairness();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
